// File: rtl/execute_stage_if.sv
// Bundle of every execute-stage signal except clock and reset.
// slave = the execute stage itself; master = whoever drives the decode latch side.
interface execute_stage_if #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
);
    // No valid/ready pair here: the decode latch presents a new instruction
    // every cycle, en=0 stalls the EX/MEM latch, and flush turns the captured
    // instruction into a bubble. Nothing is ever back-pressured combinationally.
    logic              en;
    logic              flush;
    logic [WORD_W-1:0] porta;
    logic [WORD_W-1:0] rdat2;
    logic [WORD_W-1:0] extout;
    logic [WORD_W-1:0] pc_plus_4;
    logic [WORD_W-1:0] jaddr;
    logic [3:0]        ALUop;
    logic              ALUSrc;
    logic              Branch;
    logic              bne;
    logic              Jump;
    logic              JAL;
    logic              regDst;
    logic              regWEN;
    logic              MemtoReg;
    logic              dREN;
    logic              dWEN;
    logic              halt;
    logic              datomic;
    logic [REG_W-1:0]  Rd;
    logic [REG_W-1:0]  Rt;
    logic [REG_W-1:0]  rsel1;
    logic [REG_W-1:0]  rsel2;
    logic              mem_regWEN;
    logic [REG_W-1:0]  mem_wsel;
    logic [WORD_W-1:0] mem_wdat;
    logic              wb_regWEN;
    logic [REG_W-1:0]  wb_wsel;
    logic [WORD_W-1:0] wb_wdat;
    logic              redirect;
    logic [WORD_W-1:0] npc;
    logic [WORD_W-1:0] out_aluout;
    logic [WORD_W-1:0] out_storedat;
    logic [WORD_W-1:0] out_pc_plus_4;
    logic [REG_W-1:0]  out_wsel;
    logic              out_regWEN;
    logic              out_MemtoReg;
    logic              out_dREN;
    logic              out_dWEN;
    logic              out_JAL;
    logic              out_datomic;
    logic              out_halt;
    logic              dbg_halt_stuck;

    modport slave (
        input  en, flush, porta, rdat2, extout, pc_plus_4, jaddr, ALUop,
               ALUSrc, Branch, bne, Jump, JAL, regDst, regWEN, MemtoReg,
               dREN, dWEN, halt, datomic, Rd, Rt, rsel1, rsel2,
               mem_regWEN, mem_wsel, mem_wdat, wb_regWEN, wb_wsel, wb_wdat,
        output redirect, npc, out_aluout, out_storedat, out_pc_plus_4,
               out_wsel, out_regWEN, out_MemtoReg, out_dREN, out_dWEN,
               out_JAL, out_datomic, out_halt, dbg_halt_stuck
    );

    modport master (
        output en, flush, porta, rdat2, extout, pc_plus_4, jaddr, ALUop,
               ALUSrc, Branch, bne, Jump, JAL, regDst, regWEN, MemtoReg,
               dREN, dWEN, halt, datomic, Rd, Rt, rsel1, rsel2,
               mem_regWEN, mem_wsel, mem_wdat, wb_regWEN, wb_wsel, wb_wdat,
        input  redirect, npc, out_aluout, out_storedat, out_pc_plus_4,
               out_wsel, out_regWEN, out_MemtoReg, out_dREN, out_dWEN,
               out_JAL, out_datomic, out_halt, dbg_halt_stuck
    );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and the
// EX/MEM latch with stall, flush and sticky halt.
module execute_stage #(
    parameter int WORD_W   = 32,
    parameter int REG_W    = 5,
    parameter int LINK_REG = 31
) (
    input  logic            CLK,
    input  logic            nRST,
    execute_stage_if.slave  ex
);
    localparam logic [3:0] ALU_SLL  = 4'd0;
    localparam logic [3:0] ALU_SRL  = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    typedef struct packed {
        logic [WORD_W-1:0] aluout;
        logic [WORD_W-1:0] storedat;
        logic [WORD_W-1:0] pc_plus_4;
        logic [REG_W-1:0]  wsel;
        logic              regWEN;
        logic              MemtoReg;
        logic              dREN;
        logic              dWEN;
        logic              JAL;
        logic              datomic;
        logic              halt;
    } exmem_t;

    exmem_t            exmem_q, exmem_d, exmem_new;
    logic              halt_stuck_q, halt_stuck_d;
    logic [WORD_W-1:0] fwd_a, fwd_b, op_b, alu_res;
    logic [WORD_W-1:0] branch_tgt, target;
    logic              zero, taken;

    // MEM is the younger producer, so it shadows WB; r0 is hardwired zero.
    always_comb begin
        fwd_a = ex.porta;
        if (ex.mem_regWEN && ex.mem_wsel == ex.rsel1 && ex.rsel1 != '0)
            fwd_a = ex.mem_wdat;
        else if (ex.wb_regWEN && ex.wb_wsel == ex.rsel1 && ex.rsel1 != '0)
            fwd_a = ex.wb_wdat;

        fwd_b = ex.rdat2;
        if (ex.mem_regWEN && ex.mem_wsel == ex.rsel2 && ex.rsel2 != '0)
            fwd_b = ex.mem_wdat;
        else if (ex.wb_regWEN && ex.wb_wsel == ex.rsel2 && ex.rsel2 != '0)
            fwd_b = ex.wb_wdat;
    end

    assign op_b = ex.ALUSrc ? ex.extout : fwd_b;

    always_comb begin
        alu_res = '0;
        case (ex.ALUop)
            ALU_SLL:  alu_res = fwd_a << op_b[4:0];
            ALU_SRL:  alu_res = fwd_a >> op_b[4:0];
            ALU_ADD:  alu_res = fwd_a + op_b;
            ALU_SUB:  alu_res = fwd_a - op_b;
            ALU_AND:  alu_res = fwd_a & op_b;
            ALU_OR:   alu_res = fwd_a | op_b;
            ALU_XOR:  alu_res = fwd_a ^ op_b;
            ALU_NOR:  alu_res = ~(fwd_a | op_b);
            ALU_SLT:  alu_res = {{(WORD_W-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
            ALU_SLTU: alu_res = {{(WORD_W-1){1'b0}}, fwd_a < op_b};
            default:  alu_res = '0;
        endcase
    end

    assign zero       = (alu_res == '0);
    assign taken      = ex.Branch & (zero ^ ex.bne);
    assign branch_tgt = ex.pc_plus_4 + (ex.extout << 2);
    assign target     = ex.Jump ? ex.jaddr : branch_tgt;

    // A redirect is only real if this instruction actually enters EX/MEM.
    assign ex.redirect = (taken | ex.Jump) & ex.en & ~halt_stuck_q & ~ex.flush & nRST;
    assign ex.npc      = ex.redirect ? target : ex.pc_plus_4;

    always_comb begin
        exmem_new           = '0;
        exmem_new.aluout    = ex.JAL ? ex.pc_plus_4 : alu_res;
        exmem_new.storedat  = fwd_b;
        exmem_new.pc_plus_4 = ex.pc_plus_4;
        exmem_new.wsel      = ex.JAL ? REG_W'(LINK_REG) : (ex.regDst ? ex.Rd : ex.Rt);
        exmem_new.regWEN    = ex.regWEN;
        exmem_new.MemtoReg  = ex.MemtoReg;
        exmem_new.dREN      = ex.dREN;
        exmem_new.dWEN      = ex.dWEN;
        exmem_new.JAL       = ex.JAL;
        exmem_new.datomic   = ex.datomic;
        exmem_new.halt      = ex.halt;
    end

    always_comb begin
        exmem_d      = exmem_q;
        halt_stuck_d = halt_stuck_q;
        if (!halt_stuck_q) begin
            if (ex.flush) begin
                exmem_d = '0;
            end else if (ex.en) begin
                exmem_d      = exmem_new;
                halt_stuck_d = ex.halt;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            exmem_q      <= '0;
            halt_stuck_q <= 1'b0;
        end else begin
            exmem_q      <= exmem_d;
            halt_stuck_q <= halt_stuck_d;
        end
    end

    assign ex.out_aluout     = exmem_q.aluout;
    assign ex.out_storedat   = exmem_q.storedat;
    assign ex.out_pc_plus_4  = exmem_q.pc_plus_4;
    assign ex.out_wsel       = exmem_q.wsel;
    assign ex.out_regWEN     = exmem_q.regWEN;
    assign ex.out_MemtoReg   = exmem_q.MemtoReg;
    assign ex.out_dREN       = exmem_q.dREN;
    assign ex.out_dWEN       = exmem_q.dWEN;
    assign ex.out_JAL        = exmem_q.JAL;
    assign ex.out_datomic    = exmem_q.datomic;
    assign ex.out_halt       = exmem_q.halt;
    assign ex.dbg_halt_stuck = halt_stuck_q;
endmodule
